// File: rtl/fetch_exec_ctrl.sv
// fetch_exec_ctrl: fetch-decode-execute sequencer for a 4-opcode accumulator CPU.
// Optional macro SINGLE_STEP_EN adds a step input that gates each instruction.
module fetch_exec_ctrl #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          run,
`ifdef SINGLE_STEP_EN
    input  logic          step,
`endif
    input  logic [AW-1:0] pc_addr,
    output logic [AW-1:0] pc_data,
    output logic          pc_load,
    output logic          pc_inc,
    output logic          pc_clr,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic [DW-1:0] acc,
    output logic          carry,
    output logic          halted
);

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_STA = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FETCH_W,
        DECODE,
        EXEC_W,
        NEXT,
        HALT
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] ir_pc_q, ir_pc_d;
    logic [1:0]    opcode;
    logic [AW-1:0] operand;
    logic [DW:0]   sum;

`ifdef SINGLE_STEP_EN
    logic          step_q;
    logic          step_rise;

    // Registered copy of step for rising-edge detection
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise = step & ~step_q;
`endif

    assign opcode  = ir_q[DW-1:DW-2];
    assign operand = ir_q[AW-1:0];
    assign sum     = {1'b0, acc_q} + {1'b0, mem_rdata};
    assign acc     = acc_q;
    assign carry   = carry_q;

    // State and datapath registers; clr forces the idle/reset values
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ir_q    <= '0;
            ir_pc_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
        end
    end

    // Next-state, register updates and all strobes decoded from the state
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        ir_d      = ir_q;
        ir_pc_d   = ir_pc_q;
        pc_data   = operand;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_clr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = acc_q;
        mem_we    = 1'b0;
        halted    = 1'b0;
        unique case (state_q)
            IDLE: begin
                pc_clr = 1'b1;
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_addr = pc_addr;
                ir_pc_d  = pc_addr;
                state_d  = FETCH_W;
            end
            FETCH_W: begin
                ir_d    = mem_rdata;
                pc_inc  = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                unique case (opcode)
                    OP_LDA, OP_ADD: begin
                        mem_addr = operand;
                        state_d  = EXEC_W;
                    end
                    OP_STA: begin
                        mem_addr = operand;
                        mem_we   = 1'b1;
                        state_d  = NEXT;
                    end
                    OP_JMP: begin
                        if (operand == ir_pc_q) begin
                            state_d = HALT;
                        end else begin
                            pc_load = 1'b1;
                            state_d = NEXT;
                        end
                    end
                    default: state_d = NEXT;
                endcase
            end
            EXEC_W: begin
                if (opcode == OP_ADD) begin
                    {carry_d, acc_d} = sum;
                end else begin
                    acc_d = mem_rdata;
                end
                state_d = NEXT;
            end
            NEXT: begin
`ifdef SINGLE_STEP_EN
                if (!run) begin
                    state_d = IDLE;
                end else if (step_rise) begin
                    state_d = FETCH;
                end
`else
                state_d = run ? FETCH : IDLE;
`endif
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// tb_fetch_exec_ctrl: directed bench with behavioural PC and unified memory.
// Define SINGLE_STEP_EN to also exercise the step gating.
module tb_fetch_exec_ctrl;

    logic       clk;
    logic       clr;
    logic       run;
`ifdef SINGLE_STEP_EN
    logic       step;
`endif
    logic [5:0] pc_addr;
    logic [5:0] pc_data;
    logic       pc_load;
    logic       pc_inc;
    logic       pc_clr;
    logic [5:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] acc;
    logic       carry;
    logic       halted;

    logic [7:0] mem [64];
    logic       ld_en;
    logic [5:0] ld_a;
    logic [7:0] ld_d;

    int n_run;
    int n_fail;

    fetch_exec_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .run       (run),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .pc_addr   (pc_addr),
        .pc_data   (pc_data),
        .pc_load   (pc_load),
        .pc_inc    (pc_inc),
        .pc_clr    (pc_clr),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .acc       (acc),
        .carry     (carry),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // program counter model
    always @(posedge clk) begin
        if (pc_clr) pc_addr <= '0;
        else if (pc_load) pc_addr <= pc_data;
        else if (pc_inc) pc_addr <= pc_addr + 6'd1;
    end

    // memory model: bench load port, DUT write, 1-cycle read
    always @(posedge clk) begin
        if (ld_en) mem[ld_a] <= ld_d;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic poke(input logic [5:0] a, input logic [7:0] d);
        ld_en = 1'b1;
        ld_a  = a;
        ld_d  = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic hold_clear();
        clr = 1'b1;
        run = 1'b0;
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        @(negedge clk);
        for (int i = 0; i < 64; i++) poke(i[5:0], 8'h00);
    endtask

    task automatic test_reset();
        int incs;
        hold_clear();
        n_run++;
        if (pc_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pc_clr: got %b want 1", pc_clr);
        end
        n_run++;
        if ({pc_load, pc_inc, mem_we, halted, carry, acc} !== 13'h0) begin
            n_fail++;
            $display("FAIL rst_outs: ld=%b inc=%b we=%b h=%b c=%b acc=%h want all 0",
                     pc_load, pc_inc, mem_we, halted, carry, acc);
        end
        poke(6'd0, 8'h05);
        poke(6'd5, 8'h2A);
        clr = 1'b0;
        @(negedge clk);
        n_run++;
        if (pc_clr !== 1'b1 || pc_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL idle_pc_clr: clr=%b pc=%0d want 1,0", pc_clr, pc_addr);
        end
        run = 1'b1;
        incs = 0;
        @(negedge clk);
        incs += int'(pc_inc);
        n_run++;
        if (mem_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL fetch_addr: got %0d want 0", mem_addr);
        end
        @(negedge clk);
        incs += int'(pc_inc);
        n_run++;
        if (pc_inc !== 1'b1) begin
            n_fail++;
            $display("FAIL fetchw_inc: got %b want 1", pc_inc);
        end
        @(negedge clk);
        incs += int'(pc_inc);
        n_run++;
        if (mem_addr !== 6'd5) begin
            n_fail++;
            $display("FAIL decode_addr: got %0d want 5", mem_addr);
        end
        @(negedge clk);
        incs += int'(pc_inc);
        @(negedge clk);
        incs += int'(pc_inc);
        n_run++;
        if (acc !== 8'h2A || pc_addr !== 6'd1) begin
            n_fail++;
            $display("FAIL lda_next: acc=%h pc=%0d want 2a,1", acc, pc_addr);
        end
        n_run++;
        if (incs !== 1) begin
            n_fail++;
            $display("FAIL inc_count: got %0d want 1", incs);
        end
        run = 1'b0;
    endtask

    task automatic test_program();
        int wec;
        logic [5:0] wa;
        logic [7:0] wd;
        hold_clear();
        poke(6'd0, 8'h0A);
        poke(6'd1, 8'h4B);
        poke(6'd2, 8'h8C);
        poke(6'd3, 8'hC3);
        poke(6'd10, 8'hF0);
        poke(6'd11, 8'h20);
        clr = 1'b0;
        run = 1'b1;
        wec = 0;
        wa = '0;
        wd = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_we) begin
                wec++;
                wa = mem_addr;
                wd = mem_wdata;
            end
            if (halted) break;
        end
        n_run++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL prog_halt: got %b want 1", halted);
        end
        n_run++;
        if (acc !== 8'h10 || carry !== 1'b1) begin
            n_fail++;
            $display("FAIL prog_add: acc=%h c=%b want 10,1", acc, carry);
        end
        n_run++;
        if (wec !== 1 || wa !== 6'd12 || wd !== 8'h10) begin
            n_fail++;
            $display("FAIL prog_sta: n=%0d a=%0d d=%h want 1,12,10", wec, wa, wd);
        end
        n_run++;
        if (mem[12] !== 8'h10 || pc_addr !== 6'd4) begin
            n_fail++;
            $display("FAIL prog_mem: m12=%h pc=%0d want 10,4", mem[12], pc_addr);
        end
        run = 1'b0;
    endtask

    task automatic test_jmp_halt();
        int loads;
        int bad;
        hold_clear();
        poke(6'd0, 8'hC4);
        poke(6'd4, 8'hC4);
        clr = 1'b0;
        run = 1'b1;
        loads = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pc_load) begin
                loads++;
                if (pc_data != 6'd4 || pc_inc) bad++;
            end
            if (halted) break;
        end
        n_run++;
        if (halted !== 1'b1 || loads !== 1 || bad !== 0) begin
            n_fail++;
            $display("FAIL jmp_load: h=%b loads=%0d bad=%0d want 1,1,0", halted, loads, bad);
        end
        n_run++;
        if (pc_addr !== 6'd5) begin
            n_fail++;
            $display("FAIL jmp_pc: got %0d want 5", pc_addr);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            run = i[0];
            @(negedge clk);
            if (!halted || pc_load || pc_inc || pc_clr || mem_we) bad++;
        end
        n_run++;
        if (bad !== 0 || pc_addr !== 6'd5) begin
            n_fail++;
            $display("FAIL halt_hold: bad=%0d pc=%0d want 0,5", bad, pc_addr);
        end
        run = 1'b0;
    endtask

    task automatic test_run_drop();
        bit found;
        hold_clear();
        poke(6'd0, 8'h08);
        poke(6'd1, 8'h49);
        poke(6'd8, 8'h30);
        poke(6'd9, 8'h05);
        clr = 1'b0;
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_addr == 6'd9) begin
                found = 1'b1;
                break;
            end
        end
        n_run++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_find: got %b want 1", found);
        end
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        n_run++;
        if (acc !== 8'h35 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_add: acc=%h c=%b want 35,0", acc, carry);
        end
        @(negedge clk);
        n_run++;
        if (pc_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_idle: got %b want 1", pc_clr);
        end
        @(negedge clk);
        n_run++;
        if (pc_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL drop_pc: got %0d want 0", pc_addr);
        end
        run = 1'b1;
        @(negedge clk);
        n_run++;
        if (mem_addr !== 6'd0 || pc_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_refetch: a=%0d clr=%b want 0,0", mem_addr, pc_clr);
        end
        run = 1'b0;
    endtask

    task automatic test_clr_sta();
        bit found;
        hold_clear();
        poke(6'd0, 8'h0A);
        poke(6'd1, 8'h8C);
        poke(6'd10, 8'h55);
        clr = 1'b0;
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_we) begin
                found = 1'b1;
                break;
            end
        end
        n_run++;
        if (!found || mem_addr !== 6'd12 || mem_wdata !== 8'h55) begin
            n_fail++;
            $display("FAIL sta_decode: f=%b a=%0d d=%h want 1,12,55", found, mem_addr, mem_wdata);
        end
        clr = 1'b1;
        #1;
        n_run++;
        if (mem_we !== 1'b0 || acc !== 8'h00 || pc_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_async: we=%b acc=%h clr=%b want 0,00,1", mem_we, acc, pc_clr);
        end
        @(negedge clk);
        n_run++;
        if (mem[12] !== 8'h00) begin
            n_fail++;
            $display("FAIL clr_nowrite: got %h want 00", mem[12]);
        end
        clr = 1'b0;
        run = 1'b0;
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        hold_clear();
        poke(6'd0, 8'h0A);
        poke(6'd1, 8'h4B);
        poke(6'd2, 8'h4B);
        poke(6'd10, 8'h01);
        poke(6'd11, 8'h01);
        clr = 1'b0;
        run = 1'b1;
        repeat (20) @(negedge clk);
        n_run++;
        if (acc !== 8'h01 || pc_addr !== 6'd1) begin
            n_fail++;
            $display("FAIL step_park: acc=%h pc=%0d want 01,1", acc, pc_addr);
        end
        for (int k = 2; k <= 3; k++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (10) @(negedge clk);
            n_run++;
            if (acc !== k[7:0] || pc_addr !== k[5:0]) begin
                n_fail++;
                $display("FAIL step_one: acc=%h pc=%0d want %0d,%0d", acc, pc_addr, k, k);
            end
        end
        run = 1'b0;
    endtask
`endif

    initial begin
        clk = 1'b0;
        clr = 1'b1;
        run = 1'b0;
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        ld_en = 1'b0;
        ld_a = '0;
        ld_d = '0;
        n_run = 0;
        n_fail = 0;
        test_reset();
        test_program();
        test_jmp_halt();
        test_run_drop();
        test_clr_sta();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
